div_clk_monitor: RTL
====================

Name: div_clk_monitor

Overview:
- Receiving end of the alarm's divided-clock path: samples a slow toggling signal produced by a divider, synchronizes it to clk and converts each edge into a one-cycle tick.
- Measures the half-period in clk cycles and runs a lock FSM that declares the divided clock good, lost or absent.
- Feeds seconds/minute logic with clean ticks and a health flag, so downstream counters never consume a raw divided clock.

Parameters:
- EXP_HALF, 6: expected half-period in clk cycles.
- TOL, 1: allowed +/- deviation from EXP_HALF, inclusive.
- LOCK_CNT, 4: consecutive in-tolerance measurements needed to lock.
- TIMEOUT, 24: clk cycles with no edge that force loss of lock.
- CNT_W, 8: width of the half-period measurement.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- en  in  1  monitor enable; 0 holds the block idle
- div_in  in  1  divided clock, treated as asynchronous
- rise_tick  out  1  one-cycle pulse per rising edge of div_in
- fall_tick  out  1  one-cycle pulse per falling edge of div_in
- half_period  out  CNT_W  last measured edge-to-edge distance in clk cycles
- locked  out  1  high in LOCKED state
- lost  out  1  high in LOST state
- tick_count  out  16  rising ticks counted while locked

Behaviour:
- Reset (rst=0, async): sync flops s1/s2/s3=0, rise_tick=0, fall_tick=0, half_period=0, locked=0, lost=0, tick_count=0, FSM=IDLE, all internal counters 0.
- Synchronizer: s1<=div_in, s2<=s1, s3<=s2. rise = s2&!s3, fall = !s2&s3.
  - rise_tick/fall_tick are registered and are gated by en.
  - div_in changes before posedge N; the tick is high for exactly one cycle after posedge N+2.
- Edge counter ec (CNT_W bits, saturating at all-ones):
  - Increments every cycle.
  - On the cycle a tick is issued, ec is reloaded to 1.
  - half_period is loaded with the old ec value, which is the pulse-to-pulse distance.
  - Example: div_in toggling every 6 clk gives half_period=6.
- Validity: a measurement is valid only if a previous edge exists since entering ACQUIRE. The first edge after ACQUIRE entry only starts ec and is not judged.
- Good measurement: EXP_HALF-TOL <= value <= EXP_HALF+TOL.
- Idle counter: counts cycles since the last edge. Timeout fires when it reaches TIMEOUT.
- FSM states: IDLE, ACQUIRE, LOCKED, LOST.
  - IDLE: en=1 -> ACQUIRE next cycle, with good count gc=0 and no previous edge.
  - ACQUIRE, good measurement: gc+1. When gc reaches LOCK_CNT -> LOCKED in that same cycle.
  - ACQUIRE, bad measurement: gc=0.
  - ACQUIRE, timeout: gc=0 and the previous-edge mark is cleared. Stay in ACQUIRE.
  - LOCKED: bad measurement or timeout -> LOST.
  - LOST: next edge -> ACQUIRE. gc=0, and that edge counts as the previous edge.
  - Any state: en=0 -> IDLE next cycle. Clears gc, ec and the idle counter; half_period and tick_count are held. en=0 wins over a simultaneous edge or timeout.
- locked = (state==LOCKED), lost = (state==LOST), both registered with the state.
- tick_count: increments, wrapping 16'hFFFF->0, on each rise_tick issued while already in LOCKED. A rise that causes the transition into LOCKED is not counted.
- A glitch shorter than one clk period may be missed. That is acceptable; it shows up as a bad measurement or timeout.
- Reset asserted mid-operation returns every output to its reset value immediately, with no tick emitted.

Test Plan:
1. en=1, div_in toggles every 6 clk -> one tick per edge, half_period=6. After the 5th edge (4 good measurements) locked=1. tick_count counts subsequent rises 1,2,3...
2. Locked, then one half-period of 9 clk (outside 6+/-1) -> lost=1 and locked=0 on that tick's cycle. Following 6-cycle edges: ACQUIRE, then locked again after 4 more good measurements.
3. Locked, div_in frozen high -> 24 clk after the last tick lost=1. Resuming toggles: ACQUIRE on the next edge, relock after 4 good measurements.
4. Half-periods of 5 and 7 alternate -> all good, lock after 4. A half-period of 4 during ACQUIRE resets gc, so the lock is delayed by exactly that many measurements.
5. Locked with tick_count=16'hFFFF, next rise -> tick_count=0. Drop en on the same cycle as an edge -> IDLE, no tick, locked=0, tick_count held.
6. Assert rst low mid-lock for 1 cycle -> all outputs 0 asynchronously. After release, the lock sequence restarts from IDLE/ACQUIRE.

Source files
------------

// File: rtl/div_clk_monitor.sv
// Divided-clock receiver: synchronizes div_in, emits clean edge ticks, measures the
// half-period and tracks lock/loss so downstream seconds logic sees only qualified ticks.
module div_clk_monitor #(
    parameter int EXP_HALF = 6,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 24,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             lost,
    output logic [15:0]      tick_count
);
    localparam int IC_W = $clog2(TIMEOUT + 1);
    localparam int GC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] GOOD_LO   = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] GOOD_HI   = CNT_W'(EXP_HALF + TOL);
    localparam logic [IC_W-1:0]  TIMEOUT_V = IC_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  LOCK_V    = GC_W'(LOCK_CNT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [1:0] S_LOST    = 2'd3;

    logic             r_s1, r_s2, r_s3;
    logic             r_rise_tick, r_fall_tick;
    logic [CNT_W-1:0] r_ec, r_half_period;
    logic [IC_W-1:0]  r_ic;
    logic [GC_W-1:0]  r_gc;
    logic             r_prev;
    logic [1:0]       r_state;
    logic             r_locked, r_lost;
    logic [15:0]      r_tick_count;

    logic             w_rise, w_fall, w_edge, w_good, w_timeout;
    logic [GC_W-1:0]  w_gc_inc;
    logic [1:0]       w_state_next;
    logic [GC_W-1:0]  w_gc_next;
    logic             w_prev_next;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_edge    = w_rise | w_fall;
    assign w_good    = (r_ec >= GOOD_LO) && (r_ec <= GOOD_HI);
    // An edge restarts the idle count, so it always beats a coincident timeout.
    assign w_timeout = !w_edge && (r_ic >= TIMEOUT_V);
    assign w_gc_inc  = r_gc + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_gc_next    = r_gc;
        w_prev_next  = r_prev;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_ACQUIRE;
                w_gc_next    = '0;
                w_prev_next  = 1'b0;
            end
            S_ACQUIRE: begin
                if (w_edge) begin
                    w_prev_next = 1'b1;
                    if (r_prev) begin
                        if (w_good) begin
                            w_gc_next = w_gc_inc;
                            if (w_gc_inc == LOCK_V)
                                w_state_next = S_LOCKED;
                        end else begin
                            w_gc_next = '0;
                        end
                    end
                end else if (w_timeout) begin
                    w_gc_next   = '0;
                    w_prev_next = 1'b0;
                end
            end
            S_LOCKED: begin
                if ((w_edge && !w_good) || w_timeout)
                    w_state_next = S_LOST;
            end
            default: begin
                if (w_edge) begin
                    w_state_next = S_ACQUIRE;
                    w_gc_next    = '0;
                    w_prev_next  = 1'b1;
                end
            end
        endcase
        if (!en) begin
            w_state_next = S_IDLE;
            w_gc_next    = '0;
            w_prev_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_s3          <= 1'b0;
            r_rise_tick   <= 1'b0;
            r_fall_tick   <= 1'b0;
            r_ec          <= '0;
            r_half_period <= '0;
            r_ic          <= '0;
            r_gc          <= '0;
            r_prev        <= 1'b0;
            r_state       <= S_IDLE;
            r_locked      <= 1'b0;
            r_lost        <= 1'b0;
            r_tick_count  <= '0;
        end else begin
            r_s1        <= div_in;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_rise_tick <= en & w_rise;
            r_fall_tick <= en & w_fall;
            r_gc        <= w_gc_next;
            r_prev      <= w_prev_next;
            r_state     <= w_state_next;
            r_locked    <= (w_state_next == S_LOCKED);
            r_lost      <= (w_state_next == S_LOST);
            if (!en) begin
                r_ec <= '0;
                r_ic <= '0;
            end else if (w_edge) begin
                r_half_period <= r_ec;
                r_ec          <= CNT_W'(1);
                r_ic          <= IC_W'(1);
            end else begin
                r_ec <= (r_ec == {CNT_W{1'b1}}) ? r_ec : r_ec + 1'b1;
                r_ic <= (r_ic == TIMEOUT_V) ? r_ic : r_ic + 1'b1;
            end
            // Only rises seen while already locked are counted; the locking rise is not.
            if (en && w_rise && (r_state == S_LOCKED))
                r_tick_count <= r_tick_count + 16'd1;
        end
    end

    assign rise_tick   = r_rise_tick;
    assign fall_tick   = r_fall_tick;
    assign half_period = r_half_period;
    assign locked      = r_locked;
    assign lost        = r_lost;
    assign tick_count  = r_tick_count;
endmodule
